// File: rtl/hd_pkg.sv
// Shared definitions for the boot-time disk loader: marker opcodes, error codes, FSM states.
package hd_pkg;

   // Marker words are recognised by this opcode field alone
   localparam int unsigned OP_MSB = 31;
   localparam int unsigned OP_LSB = 26;

   localparam logic [5:0] OP_HD_HEAD    = 6'b010111;
   localparam logic [5:0] OP_BEGIN_FILE = 6'b010101;
   localparam logic [5:0] OP_END_FILE   = 6'b010110;
   localparam logic [5:0] OP_HD_END     = 6'b011000;

   // Bit positions of the one-hot word class
   localparam int unsigned CLS_HD_HEAD    = 0;
   localparam int unsigned CLS_BEGIN_FILE = 1;
   localparam int unsigned CLS_END_FILE   = 2;
   localparam int unsigned CLS_HD_END     = 3;
   localparam int unsigned CLS_PAYLOAD    = 4;
   localparam int unsigned CLS_W          = 5;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_BAD_HEAD  = 2'd1;
   localparam logic [1:0] ERR_NOT_FOUND = 2'd2;
   localparam logic [1:0] ERR_BAD_FILE  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StHead,
      StSeek,
      StCopy,
      StDone,
      StErr
   } state_e;

endpackage

// File: rtl/hd_marker_decode.sv
// Classifies a disk word as one of the four markers or as payload (one-hot).
module hd_marker_decode
   import hd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] word,
   output logic [CLS_W-1:0]      cls
);

   logic [OP_MSB-OP_LSB:0] op;
   logic                   unused_low;

   assign op         = word[OP_MSB:OP_LSB];
   // Operand bits play no part in classification
   assign unused_low = ^word[OP_LSB-1:0];

   // Decode the opcode field; anything that is not a marker is payload
   always_comb begin
      cls = '0;
      unique case (op)
         OP_HD_HEAD:    cls[CLS_HD_HEAD]    = 1'b1;
         OP_BEGIN_FILE: cls[CLS_BEGIN_FILE] = 1'b1;
         OP_END_FILE:   cls[CLS_END_FILE]   = 1'b1;
         OP_HD_END:     cls[CLS_HD_END]     = 1'b1;
         default:       cls[CLS_PAYLOAD]    = 1'b1;
      endcase
   end

endmodule

// File: rtl/hd_loader.sv
// Streams the disk from address 0, checks the header, seeks to file_idx and copies its body
// into instruction memory from address 0.
module hd_loader
   import hd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned HD_ADDR_WIDTH = 9,
   parameter int unsigned IM_ADDR_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [7:0]               file_idx,
   output logic [HD_ADDR_WIDTH-1:0] hd_addr,
   output logic                     hd_we,
   input  logic [DATA_WIDTH-1:0]    hd_q,
   output logic [IM_ADDR_WIDTH-1:0] im_addr,
   output logic [DATA_WIDTH-1:0]    im_data,
   output logic                     im_we,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               err_code,
   output logic [IM_ADDR_WIDTH:0]   word_count
);

   localparam logic [HD_ADDR_WIDTH-1:0] HD_LAST = '1;
   localparam logic [IM_ADDR_WIDTH:0]   IM_FULL = {1'b1, {IM_ADDR_WIDTH{1'b0}}};

   state_e                   state;
   logic [7:0]               idx_q;
   logic [7:0]               file_cnt;
   // tag[0]: address issued last edge; tag[1]: the word on hd_q now belongs to this load
   logic [1:0]               tag;
   // Disk address of the word currently on hd_q
   logic [HD_ADDR_WIDTH-1:0] ret_addr;
   logic [CLS_W-1:0]         cls;
   logic                     active;

   assign hd_we  = 1'b0;
   assign active = (state == StHead) || (state == StSeek) || (state == StCopy);

   hd_marker_decode #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_decode (
      .word(hd_q),
      .cls (cls)
   );

   // Loader FSM with address issue, tag pipeline and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         idx_q      <= '0;
         file_cnt   <= '0;
         tag        <= '0;
         ret_addr   <= '0;
         hd_addr    <= '0;
         im_addr    <= '0;
         im_data    <= '0;
         im_we      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_code   <= ERR_NONE;
         word_count <= '0;
      end else begin
         im_we    <= 1'b0;
         done     <= 1'b0;
         ret_addr <= hd_addr;
         tag      <= {tag[0], active};
         if (active) begin
            hd_addr <= hd_addr + HD_ADDR_WIDTH'(1);
         end
         unique case (state)
            StIdle: begin
               if (start) begin
                  idx_q      <= file_idx;
                  file_cnt   <= '0;
                  word_count <= '0;
                  err_code   <= ERR_NONE;
                  im_addr    <= '0;
                  hd_addr    <= '0;
                  tag        <= 2'b01;
                  busy       <= 1'b1;
                  state      <= StHead;
               end
            end
            StHead: begin
               if (tag[1]) begin
                  if (cls[CLS_HD_HEAD]) begin
                     state <= StSeek;
                  end else begin
                     err_code <= ERR_BAD_HEAD;
                     busy     <= 1'b0;
                     state    <= StErr;
                  end
               end
            end
            StSeek: begin
               if (tag[1]) begin
                  if (cls[CLS_BEGIN_FILE] && (file_cnt == idx_q)) begin
                     state <= StCopy;
                  end else if (cls[CLS_HD_END] || (ret_addr == HD_LAST)) begin
                     err_code <= ERR_NOT_FOUND;
                     busy     <= 1'b0;
                     state    <= StErr;
                  end else if (cls[CLS_BEGIN_FILE]) begin
                     file_cnt <= file_cnt + 8'd1;
                  end
               end
            end
            StCopy: begin
               if (tag[1]) begin
                  // Returned address 0 while copying means the disk wrapped
                  if (ret_addr == '0) begin
                     err_code <= ERR_BAD_FILE;
                     busy     <= 1'b0;
                     state    <= StErr;
                  end else if (cls[CLS_END_FILE]) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= StDone;
                  end else if (cls[CLS_PAYLOAD] && (word_count != IM_FULL)) begin
                     im_we      <= 1'b1;
                     im_data    <= hd_q;
                     im_addr    <= word_count[IM_ADDR_WIDTH-1:0];
                     word_count <= word_count + (IM_ADDR_WIDTH + 1)'(1);
                  end else begin
                     err_code <= ERR_BAD_FILE;
                     busy     <= 1'b0;
                     state    <= StErr;
                  end
               end
            end
            StDone, StErr: state <= StIdle;
            default:       state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hd_loader.sv
// Randomised and directed bench for hd_loader against a scan-the-image reference model.
module tb_hd_loader;

   localparam logic [5:0] M_HEAD  = 6'b010111;
   localparam logic [5:0] M_BEGIN = 6'b010101;
   localparam logic [5:0] M_END   = 6'b010110;
   localparam logic [5:0] M_HDEND = 6'b011000;
   localparam int         BUDGET  = 700;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  file_idx;
   logic [8:0]  hd_addr;
   logic        hd_we;
   logic [31:0] hd_q;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic        im_we;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [10:0] word_count;

   always #5 clk = ~clk;

   // Disk model: address registered inside the disk, data read combinationally from it
   logic [31:0] disk [512];
   logic [8:0]  rd_addr;
   always @(posedge clk) rd_addr <= hd_addr;
   assign hd_q = disk[rd_addr];

   hd_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .file_idx  (file_idx),
      .hd_addr   (hd_addr),
      .hd_we     (hd_we),
      .hd_q      (hd_q),
      .im_addr   (im_addr),
      .im_data   (im_data),
      .im_we     (im_we),
      .busy      (busy),
      .done      (done),
      .err_code  (err_code),
      .word_count(word_count)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model results
   logic [31:0] exp_data[$];
   int          exp_err, exp_wc, exp_term;

   function automatic logic [5:0] opc(input logic [31:0] w);
      return w[31:26];
   endfunction

   // Walk the image by the loader's rules; exp_term is the disk address that ends the load
   function automatic void model(input int idx);
      int          a;
      int          cnt;
      logic [5:0]  o;
      exp_data.delete();
      exp_wc = 0;
      cnt    = 0;
      if (opc(disk[0]) != M_HEAD) begin
         exp_err = 1; exp_term = 0; return;
      end
      for (a = 1; a < 512; a++) begin
         o = opc(disk[a]);
         if (o == M_BEGIN && cnt == idx) break;
         if (o == M_HDEND || a == 511) begin
            exp_err = 2; exp_term = a; return;
         end
         if (o == M_BEGIN) cnt++;
      end
      for (a = a + 1; a <= 512; a++) begin
         if (a == 512) begin
            exp_err = 3; exp_term = 512; return;
         end
         o = opc(disk[a]);
         if (o == M_END) begin
            exp_err = 0; exp_term = a; return;
         end
         if (o inside {M_BEGIN, M_HEAD, M_HDEND} || exp_wc == 1024) begin
            exp_err = 3; exp_term = a; return;
         end
         exp_data.push_back(disk[a]);
         exp_wc++;
      end
   endfunction

   // Observations of the last load
   logic [31:0] got_data[$];
   int          got_addr[$];
   int          term_edge, done_edge, last_wr_edge;

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hd_addr"}, hd_addr, 0);
      chk({tag, "_im_addr"}, im_addr, 0);
      chk({tag, "_im_data"}, im_data, 0);
      chk({tag, "_im_we"}, im_we, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_code, 0);
      chk({tag, "_wc"}, word_count, 0);
      chk({tag, "_hd_we"}, hd_we, 0);
   endtask

   // One load; rst_at > 0 aborts with reset after that edge, poke_at > 0 re-pulses start
   task automatic run_load(input int idx, input int rst_at, input int poke_at);
      model(idx);
      got_data.delete();
      got_addr.delete();
      term_edge    = -1;
      done_edge    = -1;
      last_wr_edge = -1;
      @(negedge clk);
      start    = 1'b1;
      file_idx = 8'(idx);
      @(posedge clk); #1;
      start = 1'b0;
      chk("e0_busy", busy, 1);
      chk("e0_err", err_code, 0);
      chk("e0_wc", word_count, 0);
      chk("e0_hd_addr", hd_addr, 0);
      for (int c = 1; c <= BUDGET; c++) begin
         @(posedge clk); #1;
         start    = 1'b0;
         file_idx = 8'(idx);
         if (im_we) begin
            got_data.push_back(im_data);
            got_addr.push_back(int'(im_addr));
            last_wr_edge = c;
         end
         if (done) done_edge = c;
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (!busy) begin
            term_edge = c;
            break;
         end
         if (c == poke_at) begin
            start    = 1'b1;
            file_idx = 8'(idx + 1);
         end
      end
      chk("term_edge", term_edge, exp_term + 2);
      chk("err_code", err_code, exp_err);
      chk("word_count", word_count, exp_wc);
      chk("done_edge", done_edge, (exp_err == 0) ? exp_term + 2 : -1);
      chk("n_writes", got_data.size(), exp_data.size());
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         chk("wr_addr", got_addr[i], i);
         chk("wr_data", got_data[i], exp_data[i]);
      end
      @(posedge clk); #1;
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_err", err_code, exp_err);
      chk("hd_we", hd_we, 0);
   endtask

   function automatic logic [31:0] pay_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] inside {M_HEAD, M_BEGIN, M_END, M_HDEND}) w[31:26] = 6'h00;
      return w;
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] o);
      logic [25:0] r;
      r = 26'($urandom);
      return {o, r};
   endfunction

   task automatic build_std();
      for (int i = 0; i < 512; i++) disk[i] = 32'h0;
      disk[0] = {M_HEAD, 26'h0};
      disk[1] = {M_BEGIN, 26'h0};
      for (int a = 2; a <= 32; a++) disk[a] = {6'd5, 26'(a - 2)};
      disk[5]  = 32'h3000_0000;
      disk[33] = {M_END, 26'h0};
      disk[34] = {M_HDEND, 26'h0};
   endtask

   task automatic gen_random(output int nf);
      int a;
      for (int i = 0; i < 512; i++) disk[i] = pay_word();
      disk[0] = ($urandom_range(0, 9) == 0) ? pay_word() : mk(M_HEAD);
      a  = 1;
      nf = int'($urandom_range(1, 4));
      for (int f = 0; f < nf; f++) begin
         a += int'($urandom_range(0, 2));
         disk[a] = mk(M_BEGIN);
         a++;
         a += int'($urandom_range(0, 8));
         case ($urandom_range(0, 9))
            0:       disk[a] = mk(M_BEGIN);
            1:       disk[a] = mk(M_HEAD);
            default: disk[a] = mk(M_END);
         endcase
         a++;
      end
      if ($urandom_range(0, 5) != 0) disk[a] = mk(M_HDEND);
   endtask

   initial begin
      int nf;
      rst_n    = 1'b0;
      start    = 1'b0;
      file_idx = 8'd0;
      for (int i = 0; i < 512; i++) disk[i] = 32'h0;
      #2;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("idle");

      // Standard image, file 0
      build_std();
      run_load(0, 0, 0);
      chk("std_last_wr_edge", last_wr_edge, 34);
      chk("std_done_edge", done_edge, 35);
      chk("std_wc", word_count, 31);
      chk("std_nop", (got_data.size() > 3) ? got_data[3] : 32'hx, 32'h3000_0000);
      chk("std_last_data", (got_data.size() > 0) ? got_data[got_data.size() - 1] : 32'hx,
          32'h1400_001E);

      // File 1 does not exist
      run_load(1, 0, 0);
      chk("nf_err", err_code, 2);
      chk("nf_writes", got_data.size(), 0);

      // Bad header
      disk[0] = 32'h0;
      run_load(0, 0, 0);
      chk("bh_err", err_code, 1);
      chk("bh_term", term_edge, 2);
      chk("bh_writes", got_data.size(), 0);
      disk[0] = {M_HEAD, 26'h0};

      // Unterminated file, then a fresh start clears the error
      disk[33] = {M_BEGIN, 26'h0};
      run_load(0, 0, 0);
      chk("bf_err", err_code, 3);
      chk("bf_writes", got_data.size(), 31);
      chk("bf_done", done_edge, -1);
      build_std();
      run_load(0, 0, 0);
      chk("bf_recover_err", err_code, 0);

      // Two files, load the second
      disk[34] = {M_BEGIN, 26'h0};
      for (int k = 0; k < 3; k++) disk[35 + k] = 32'h0800_0001 + 32'(k);
      disk[38] = {M_END, 26'h0};
      disk[39] = {M_HDEND, 26'h0};
      run_load(1, 0, 0);
      chk("two_wc", word_count, 3);
      for (int k = 0; k < 3 && k < got_data.size(); k++)
         chk("two_data", got_data[k], 32'h0800_0001 + 32'(k));

      // Reset mid-load, then a clean reload; then start re-pulsed mid-load
      build_std();
      run_load(0, 10, 0);
      run_load(0, 0, 0);
      chk("rst_reload_wc", word_count, 31);
      run_load(0, 0, 10);
      chk("poke_wc", word_count, 31);
      chk("poke_done_edge", done_edge, 35);

      // Random images and indices
      for (int t = 0; t < 25; t++) begin
         gen_random(nf);
         run_load(int'($urandom_range(0, nf)), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hd_loader.md
# hd_loader

Boot-time reader for the simulated hard disk. On `start` it streams words from disk address 0, validates the disk header and skips to file number `file_idx`. It then copies that file's body into instruction memory starting at instruction address 0, and reports `done` or an error code. It sits between the disk model's read port and the instruction memory write port, and runs before the CPU leaves reset.

## Interface
- `DATA_WIDTH`, 32, disk and instruction word width
- `HD_ADDR_WIDTH`, 9, disk address width (disk depth 2**HD_ADDR_WIDTH)
- `IM_ADDR_WIDTH`, 10, instruction memory address width
- `clk` in 1 — single clock; all logic is on the rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin a load; sampled only in IDLE
- `file_idx` in 8 — zero-based index of the file to load; sampled with `start`
- `hd_addr` out HD_ADDR_WIDTH — registered disk read address
- `hd_we` out 1 — tied 0; the loader never writes the disk
- `hd_q` in DATA_WIDTH — disk read data; its address is registered inside the disk
- `im_addr` out IM_ADDR_WIDTH — instruction memory write address
- `im_data` out DATA_WIDTH — instruction memory write data
- `im_we` out 1 — one-cycle write strobe per copied word
- `busy` out 1 — high from the `start` acceptance edge until DONE or ERR is entered
- `done` out 1 — one-cycle pulse on success
- `err_code` out 2 — 0 none, 1 BAD_HEAD, 2 NOT_FOUND, 3 BAD_FILE; holds until the next accepted `start`
- `word_count` out IM_ADDR_WIDTH+1 — number of words written by the last load

## Operation
- Marker words are identified by bits [31:26] only:
  - HD_HEAD = 6'b010111
  - BEGIN_FILE = 6'b010101
  - END_FILE = 6'b010110
  - HD_END = 6'b011000
  - Any other opcode is a payload word.
- FSM states are IDLE, HEAD, SEEK, COPY, DONE, ERR.
- IDLE: on `start`, latch `file_idx`, clear `word_count`, `err_code`, the file counter and `im_addr`; go to HEAD.
- Address issue: from the acceptance edge onward, `hd_addr` is set to 0 and increments by 1 every cycle while in HEAD, SEEK or COPY. A 2-deep tag pipeline marks which returned word is valid.
- HEAD: the first returned word (address 0) must be HD_HEAD. Otherwise go to ERR with code 1. If it is HD_HEAD, go to SEEK.
- SEEK:
  - Each BEGIN_FILE seen while file counter == `file_idx` moves to COPY.
  - Each BEGIN_FILE seen while the counter is lower increments the counter.
  - HD_END, or the returned address reaching 2**HD_ADDR_WIDTH-1 without a match, goes to ERR with code 2.
- COPY:
  - Each payload word asserts `im_we` with `im_data` = word and `im_addr` = word_count, then increments `word_count`.
  - END_FILE goes to DONE.
  - BEGIN_FILE, HD_HEAD, HD_END, disk address wrap, or a write attempt with word_count == 2**IM_ADDR_WIDTH goes to ERR with code 3. That word is not written.
- DONE and ERR: pulse `done` (DONE only) for one cycle, deassert `busy`, return to IDLE next cycle.
- Up to 2 words read past a terminator are discarded and never written.
- An empty file (BEGIN_FILE immediately followed by END_FILE) succeeds with `word_count` = 0.
- `start` while busy is ignored.

## Timing
- Reset values: `hd_addr`=0, `hd_we`=0, `im_addr`=0, `im_data`=0, `im_we`=0, `busy`=0, `done`=0, `err_code`=0, `word_count`=0, state IDLE.
- Reset asserted mid-load clears everything immediately, `im_we` included. Memory contents already written are left as they are.
- Read latency: the address registered at edge k is sampled as `hd_q` at edge k+2.
- Edge numbering below counts the `start` acceptance edge as E0.
  - Word at disk address a is evaluated at E(a+2).
  - `im_we`, `done` and state changes are registered outputs driven by that evaluation edge.
- Throughput is one word per cycle. There is no back-pressure.

## Structure
- Shared package `hd_pkg` holds:
  - the marker opcode constants and the marker opcode field position [31:26]
  - the `err_code` values
  - the FSM state enum
- The marker and payload classification is combinational. A separate `hd_marker_decode` sub-module (word in, one-hot marker class out) is natural, because the disk-side tools reuse it.

## Test plan
- Standard image, file_idx=0 (HD_HEAD at 0, BEGIN_FILE at 1, payload at 2..32, END_FILE at 33, HD_END at 34):
  - 31 writes, to im_addr 0..30.
  - im_addr 3 gets 32'h30000000 (the nop at disk address 5).
  - Last write (im_addr 30, data 32'h1400001E) at E34.
  - `done` pulses at E35, `word_count`=31, `err_code`=0.
- Same image, file_idx=1: HD_END is seen in SEEK; ERR with code 2, no `im_we`, `busy` drops.
- Word 0 replaced with 32'h00000000: `err_code`=1 after E2, zero writes.
- END_FILE at address 33 replaced by BEGIN_FILE:
  - 31 writes, then `err_code`=3, no `done`.
  - A following `start` clears `err_code` to 0.
- Two files (the second is 3 payload words 32'h08000001..3 at addresses 35..37, bounded by BEGIN_FILE/END_FILE), file_idx=1: exactly 3 writes to im_addr 0..2, `word_count`=3.
- Reset:
  - `rst_n` pulled low at E10 of a file-0 load: all outputs go to 0 asynchronously.
  - A new `start` then reproduces the full file-0 result.
  - `start` pulsed again mid-load has no effect.
